// File: rtl/spi_slave_responder.sv
// SPI slave responder: full-duplex byte engine on the system clock.
// Synchronizes sclk/cs_n/mosi and offers a one-deep tx buffer.
module spi_slave_responder #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              underrun,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  state_t            r_state;
  logic              r_cpol;
  logic              r_cpha;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_tx_sh;
  logic [DATA_W-1:0] r_rx_sh;
  logic [DATA_W-1:0] r_tx_buf;
  logic              r_tx_ready;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_underrun;
  logic              r_miso;
  logic              r_miso_oe;
  logic              r_busy;

  logic              w_sclk_s;
  logic              w_cs_s;
  logic              w_mosi_s;
  logic              w_sclk_rise;
  logic              w_sclk_fall;
  logic              w_cs_fall;
  logic              w_cs_rise;
  logic              w_lead;
  logic              w_trail;
  logic              w_sample;
  logic              w_shift;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_rx_next;

  function automatic logic f_first(
    input logic [DATA_W-1:0] v
  );
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] f_pop(
    input logic [DATA_W-1:0] v
  );
    return MSB_FIRST ? {v[DATA_W-2:0], 1'b0}
                     : {1'b0, v[DATA_W-1:1]};
  endfunction

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
  assign w_cs_fall   = ~w_cs_s & r_cs_prev;
  assign w_cs_rise   = w_cs_s & ~r_cs_prev;

  assign w_lead   = r_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail  = r_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample = r_cpha ? w_trail : w_lead;
  assign w_shift  = r_cpha ? w_lead : w_trail;

  // empty buffer feeds zeros into the shifter
  assign w_load = r_tx_ready ? '0 : r_tx_buf;

  assign w_rx_next = MSB_FIRST
    ? {r_rx_sh[DATA_W-2:0], w_mosi_s}
    : {w_mosi_s, r_rx_sh[DATA_W-1:1]};

  // Input synchronizers; cs_n resets as "selected" so a select
  // held low through reset cannot start a frame on its own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  // Frame FSM, shifters, tx buffer and host-side strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_cnt      <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_tx_buf   <= '0;
      r_tx_ready <= 1'b1;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_miso     <= 1'b0;
      r_miso_oe  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      if (tx_load && r_tx_ready) begin
        r_tx_buf   <= tx_data;
        r_tx_ready <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_state   <= S_ACTIVE;
            r_cpol    <= mode[1];
            r_cpha    <= mode[0];
            r_cnt     <= '0;
            r_rx_sh   <= '0;
            r_busy    <= 1'b1;
            r_miso_oe <= 1'b1;
            if (r_tx_ready) r_underrun <= 1'b1;
            else            r_tx_ready <= 1'b1;
            // CPHA=0 puts the first bit out right away
            if (mode[0]) begin
              r_tx_sh <= w_load;
            end else begin
              r_tx_sh <= f_pop(w_load);
              r_miso  <= f_first(w_load);
            end
          end
        end
        S_ACTIVE: begin
          if (w_shift) begin
            r_miso  <= f_first(r_tx_sh);
            r_tx_sh <= f_pop(r_tx_sh);
          end
          if (w_sample) begin
            r_rx_sh <= w_rx_next;
            if (r_cnt == LAST) begin
              r_cnt      <= '0;
              r_rx_data  <= w_rx_next;
              r_rx_valid <= 1'b1;
              if (!w_cs_rise) begin
                r_tx_sh <= w_load;
                if (r_tx_ready) r_underrun <= 1'b1;
                else            r_tx_ready <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          if (w_cs_rise) begin
            r_state   <= S_IDLE;
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_rx_sh   <= '0;
            r_tx_sh   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign miso     = r_miso;
  assign miso_oe  = r_miso_oe;
  assign tx_ready = r_tx_ready;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign underrun = r_underrun;
  assign busy     = r_busy;

endmodule
